dl_ante_checker: RTL



---
 rtl/dl_ante_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dl_ante_checker.sv
// Downlink antenna stream checker: forwards packets one cycle late and flags length and sequence errors.
// Ports: clk_in/rst, cnt_clr, din_* stream in, dout_* stream out with error pulses, status counters, busy.
module dl_ante_checker #(
    parameter int SCS_NUM    = 3276,
    parameter int ANTE_NUM   = 4,
    parameter int SYMBOL_NUM = 14,
    parameter int SLOT_NUM   = 20,
    parameter int FRAME_NUM  = 1024
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        cnt_clr,
    input  logic        din_valid,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic [63:0] din_data,
    input  logic [15:0] din_frame,
    input  logic [7:0]  din_slot,
    input  logic [7:0]  din_symbol,
    input  logic [7:0]  din_ante,
    output logic        dout_valid,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [63:0] dout_data,
    output logic [15:0] dout_frame,
    output logic [7:0]  dout_slot,
    output logic [7:0]  dout_symbol,
    output logic [7:0]  dout_ante,
    output logic        dout_len_err,
    output logic        dout_seq_err,
    output logic        dout_abort,
    output logic [31:0] pkt_cnt,
    output logic [31:0] len_err_cnt,
    output logic [31:0] seq_err_cnt,
    output logic [31:0] orphan_cnt,
    output logic        busy
);

    localparam logic [11:0] DATA_WORDS = 12'(SCS_NUM / 4);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]  state;
    logic        first;
    logic [11:0] word_cnt;
    logic [15:0] exp_frame;
    logic [7:0]  exp_slot;
    logic [7:0]  exp_symbol;
    logic [7:0]  exp_ante;

    logic        in_recv;
    logic        is_sop;
    logic        fwd;
    logic        orphan;
    logic        abort;
    logic        is_eop;
    logic        len_err;
    logic        mismatch;
    logic [11:0] len_next;
    logic [1:0]  len_inc;
    logic        wrap_a;
    logic        wrap_s;
    logic        wrap_l;
    logic [15:0] nxt_frame;
    logic [7:0]  nxt_slot;
    logic [7:0]  nxt_symbol;
    logic [7:0]  nxt_ante;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] n);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, n};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign in_recv = (state == RECV);
    assign busy    = in_recv;
    assign is_sop  = din_valid & din_sop;
    // Words outside a packet are dropped; anything else is forwarded.
    assign fwd     = din_valid & (din_sop | in_recv);
    assign orphan  = din_valid & ~din_sop & ~in_recv;
    assign abort   = is_sop & in_recv;
    assign is_eop  = fwd & din_eop;

    // Length including the current word, saturating at 4095.
    assign len_next = din_sop ? 12'd1 :
                      (word_cnt == 12'hFFF) ? word_cnt : word_cnt + 12'd1;
    assign len_err  = is_eop & (len_next != DATA_WORDS);
    assign len_inc  = {1'b0, abort} + {1'b0, len_err};

    assign mismatch = is_sop & ~first &
                      ({din_frame, din_slot, din_symbol, din_ante} !=
                       {exp_frame, exp_slot, exp_symbol, exp_ante});

    // Expected key for the next packet is always derived from the key just
    // received, which covers both the normal advance and the resync.
    always_comb begin
        wrap_a     = din_ante >= 8'(ANTE_NUM - 1);
        wrap_s     = wrap_a & (din_symbol >= 8'(SYMBOL_NUM - 1));
        wrap_l     = wrap_s & (din_slot >= 8'(SLOT_NUM - 1));
        nxt_ante   = wrap_a ? 8'd0 : din_ante + 8'd1;
        nxt_symbol = din_symbol;
        nxt_slot   = din_slot;
        nxt_frame  = din_frame;
        if (wrap_a)
            nxt_symbol = wrap_s ? 8'd0 : din_symbol + 8'd1;
        if (wrap_s)
            nxt_slot = wrap_l ? 8'd0 : din_slot + 8'd1;
        if (wrap_l)
            nxt_frame = (din_frame >= 16'(FRAME_NUM - 1)) ? 16'd0 : din_frame + 16'd1;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            first        <= 1'b1;
            word_cnt     <= 12'd0;
            exp_frame    <= 16'd0;
            exp_slot     <= 8'd0;
            exp_symbol   <= 8'd0;
            exp_ante     <= 8'd0;
            dout_valid   <= 1'b0;
            dout_sop     <= 1'b0;
            dout_eop     <= 1'b0;
            dout_data    <= 64'd0;
            dout_frame   <= 16'd0;
            dout_slot    <= 8'd0;
            dout_symbol  <= 8'd0;
            dout_ante    <= 8'd0;
            dout_len_err <= 1'b0;
            dout_seq_err <= 1'b0;
            dout_abort   <= 1'b0;
            pkt_cnt      <= 32'd0;
            len_err_cnt  <= 32'd0;
            seq_err_cnt  <= 32'd0;
            orphan_cnt   <= 32'd0;
        end else begin
            dout_valid   <= fwd;
            dout_sop     <= fwd & din_sop;
            dout_eop     <= is_eop;
            dout_len_err <= len_err;
            dout_seq_err <= mismatch;
            dout_abort   <= abort;
            if (fwd) begin
                dout_data <= din_data;
                word_cnt  <= len_next;
            end
            if (is_sop) begin
                dout_frame  <= din_frame;
                dout_slot   <= din_slot;
                dout_symbol <= din_symbol;
                dout_ante   <= din_ante;
                exp_frame   <= nxt_frame;
                exp_slot    <= nxt_slot;
                exp_symbol  <= nxt_symbol;
                exp_ante    <= nxt_ante;
            end
            if (din_valid) begin
                case (state)
                    IDLE:    if (din_sop && !din_eop) state <= RECV;
                    RECV:    if (din_eop) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (cnt_clr) begin
                first       <= 1'b1;
                pkt_cnt     <= 32'd0;
                len_err_cnt <= 32'd0;
                seq_err_cnt <= 32'd0;
                orphan_cnt  <= 32'd0;
            end else begin
                if (is_sop)
                    first <= 1'b0;
                pkt_cnt     <= sat_add(pkt_cnt, {1'b0, is_eop});
                len_err_cnt <= sat_add(len_err_cnt, len_inc);
                seq_err_cnt <= sat_add(seq_err_cnt, {1'b0, mismatch});
                orphan_cnt  <= sat_add(orphan_cnt, {1'b0, orphan});
            end
        end
    end

endmodule
